// File: rtl/olivia_pkg.sv
// Shared definitions for the load/store unit memory stage.
//   lsu_state_t     : FSM state encoding (IDLE / ACCESS / RESP)
//   lsu_size_t      : access size encoding (byte / doubleword)
//   XZR_IDX         : register index that discards writes
//   TIMEOUT_DEFAULT : default ack timeout in cycles
package olivia_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } lsu_state_t;

  typedef enum logic {
    SIZE_BYTE  = 1'b0,
    SIZE_DWORD = 1'b1
  } lsu_size_t;

  localparam logic [4:0]  XZR_IDX         = 5'd31;
  localparam int unsigned TIMEOUT_DEFAULT = 64;

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane steering for the memory stage.
// Ports:
//   st_size_i, st_lane_i, st_data_i : store size, byte lane and register data
//   st_wstrb_o, st_wdata_o          : write strobe and lane-replicated write data
//   ld_size_i, ld_lane_i, ld_rdata_i: load size, byte lane and raw RAM data
//   ld_data_o                       : zero-extended load result
module lsu_lane_align
  import olivia_pkg::*;
(
  input  logic        st_size_i,
  input  logic [2:0]  st_lane_i,
  input  logic [63:0] st_data_i,
  input  logic        ld_size_i,
  input  logic [2:0]  ld_lane_i,
  input  logic [63:0] ld_rdata_i,
  output logic [7:0]  st_wstrb_o,
  output logic [63:0] st_wdata_o,
  output logic [63:0] ld_data_o
);

  always_comb begin
    st_wstrb_o = 8'hFF;
    st_wdata_o = st_data_i;
    ld_data_o  = ld_rdata_i;
    if (st_size_i == SIZE_BYTE) begin
      // The byte is copied to every lane so the strobe alone selects the target.
      st_wstrb_o = 8'h01 << st_lane_i;
      st_wdata_o = {8{st_data_i[7:0]}};
    end
    if (ld_size_i == SIZE_BYTE) begin
      ld_data_o = {56'd0, ld_rdata_i[{ld_lane_i, 3'b000} +: 8]};
    end
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Memory stage of the load/store unit: accepts one EX result at a time,
// performs at most one data-RAM access and emits a single-cycle write-back.
// Ports:
//   clk, rst (async, active-low)
//   ex_valid/ex_ready, mem_read, mem_write, size, addr, store_data, rd : EX offer
//   wb_valid, wb_we, wb_rd, wb_data, wb_fault                          : write-back
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, mem_ack, mem_rdata: data RAM
//   dbg_state                                                          : FSM state
//
// Handshake: an EX offer transfers on a rising edge where ex_valid and ex_ready
// are both 1; ex_ready is 1 only in IDLE and inputs are ignored otherwise. The
// RAM completes a request on a rising edge where mem_req and mem_ack are both 1;
// mem_req and its attributes stay constant until then. Write-back has no ready.
module lsu_mem_stage
  import olivia_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        size,
  input  logic [63:0] addr,
  input  logic [63:0] store_data,
  input  logic [4:0]  rd,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        wb_fault,
  output logic        mem_req,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [63:0] mem_rdata,
  output lsu_state_t  dbg_state
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             size_q;
  logic [2:0]       lane_q;
  logic             is_load_q;
  logic             wb_valid_q, wb_we_q, wb_fault_q;
  logic [4:0]       wb_rd_q;
  logic [63:0]      wb_data_q;
  logic             mem_req_q, mem_we_q;
  logic [63:0]      mem_addr_q, mem_wdata_q;
  logic [7:0]       mem_wstrb_q;

  logic [7:0]  st_wstrb;
  logic [63:0] st_wdata, ld_data;
  logic        is_nonmem, is_bad;

  // Store steering uses the live offer (registered at transfer); load steering
  // uses the captured size/lane because the data arrives later with mem_ack.
  lsu_lane_align u_lane_align (
    .st_size_i  (size),
    .st_lane_i  (addr[2:0]),
    .st_data_i  (store_data),
    .ld_size_i  (size_q),
    .ld_lane_i  (lane_q),
    .ld_rdata_i (mem_rdata),
    .st_wstrb_o (st_wstrb),
    .st_wdata_o (st_wdata),
    .ld_data_o  (ld_data)
  );

  assign is_nonmem = !mem_read && !mem_write;
  assign is_bad    = (mem_read && mem_write) ||
                     ((size == SIZE_DWORD) && (addr[2:0] != 3'b000));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      size_q      <= 1'b0;
      lane_q      <= 3'd0;
      is_load_q   <= 1'b0;
      wb_valid_q  <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_fault_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= 64'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      mem_wstrb_q <= 8'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (ex_valid) begin
            wb_rd_q   <= rd;
            size_q    <= size;
            lane_q    <= addr[2:0];
            is_load_q <= mem_read;
            cnt_q     <= '0;
            if (is_nonmem) begin
              state_q    <= ST_RESP;
              wb_valid_q <= 1'b1;
              wb_we_q    <= (rd != XZR_IDX);
              wb_fault_q <= 1'b0;
              wb_data_q  <= addr;
            end else if (is_bad) begin
              state_q    <= ST_RESP;
              wb_valid_q <= 1'b1;
              wb_we_q    <= 1'b0;
              wb_fault_q <= 1'b1;
              wb_data_q  <= 64'd0;
            end else begin
              state_q     <= ST_ACCESS;
              mem_req_q   <= 1'b1;
              mem_we_q    <= mem_write;
              mem_addr_q  <= {addr[63:3], 3'b000};
              mem_wdata_q <= mem_write ? st_wdata : 64'd0;
              mem_wstrb_q <= mem_write ? st_wstrb : 8'd0;
            end
          end
        end
        ST_ACCESS: begin
          // An ack in the final counted cycle still completes the access.
          if (mem_ack) begin
            state_q    <= ST_RESP;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_fault_q <= 1'b0;
            wb_we_q    <= is_load_q && (wb_rd_q != XZR_IDX);
            wb_data_q  <= is_load_q ? ld_data : 64'd0;
          end else if (cnt_q == CNT_LAST) begin
            state_q    <= ST_RESP;
            mem_req_q  <= 1'b0;
            mem_we_q   <= 1'b0;
            wb_valid_q <= 1'b1;
            wb_fault_q <= 1'b1;
            wb_we_q    <= 1'b0;
            wb_data_q  <= 64'd0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q    <= ST_IDLE;
          wb_valid_q <= 1'b0;
          wb_we_q    <= 1'b0;
          wb_fault_q <= 1'b0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Gated by rst so ex_ready is 0 during reset yet 1 in the first cycle after.
  assign ex_ready  = rst && (state_q == ST_IDLE);
  assign wb_valid  = wb_valid_q;
  assign wb_we     = wb_we_q;
  assign wb_rd     = wb_rd_q;
  assign wb_data   = wb_data_q;
  assign wb_fault  = wb_fault_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wstrb = mem_wstrb_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

  localparam int TMO = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        ex_valid = 0, ex_ready, mem_read = 0, mem_write = 0, size = 0;
  logic [63:0] addr = 0, store_data = 0, mem_rdata = 0;
  logic [4:0]  rd = 0;
  logic        wb_valid, wb_we, wb_fault, mem_req, mem_we, mem_ack = 0;
  logic [4:0]  wb_rd;
  logic [63:0] wb_data, mem_addr, mem_wdata;
  logic [7:0]  mem_wstrb;
  olivia_pkg::lsu_state_t dbg_state;

  lsu_mem_stage #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .mem_read(mem_read), .mem_write(mem_write), .size(size), .addr(addr),
    .store_data(store_data), .rd(rd), .wb_valid(wb_valid), .wb_we(wb_we),
    .wb_rd(wb_rd), .wb_data(wb_data), .wb_fault(wb_fault), .mem_req(mem_req),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [63:0] exp_q[$];

  typedef struct {
    int req_cycles; int lat; int wbv_cycles;
    bit unstable; bit ready0; bit ready_after; bit timed_out;
    logic [63:0] maddr; logic [63:0] mwdata; logic [7:0] mwstrb; logic mwe;
    logic we; logic fault; logic [4:0] wrd; logic [63:0] wdata;
  } obs_t;

  typedef struct {
    int req_cycles; int lat; logic fault; logic we;
    bit chk_data; logic [63:0] data; bit chk_wr;
    logic [63:0] maddr; logic [63:0] mwdata; logic [7:0] mwstrb; logic mwe;
  } exp_t;

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic rdn, wrn, sz, input logic [63:0] a, sd,
                                 input logic [4:0] r, input int ack_lat, input logic [63:0] rdata);
    exp_t e;
    int lane;
    e = '{default: 0};
    lane = int'(a % 64'd8);
    e.maddr = a - (a % 64'd8);
    if (!rdn && !wrn) begin
      e.lat = 1; e.we = (r != 5'd31); e.chk_data = 1; e.data = a;
    end else if ((rdn && wrn) || (sz && lane != 0)) begin
      e.lat = 1; e.fault = 1;
    end else begin
      e.mwe = wrn;
      if (wrn) begin
        e.chk_wr = 1;
        e.mwstrb = sz ? 8'hFF : 8'(1 << lane);
        e.mwdata = sz ? sd : {56'd0, sd[7:0]} * 64'h0101010101010101;
      end
      if (ack_lat < 1 || ack_lat > TMO) begin
        e.req_cycles = TMO; e.lat = TMO + 1; e.fault = 1;
      end else begin
        e.req_cycles = ack_lat; e.lat = ack_lat + 1;
        if (rdn) begin
          e.we = (r != 5'd31); e.chk_data = 1;
          e.data = sz ? rdata : (rdata >> (8 * lane)) & 64'hFF;
        end
      end
    end
    return e;
  endfunction

  // ---------------- driver: one op plus RAM responder ----------------
  // ack_lat = n: ack in the n-th mem_req cycle; 0 = never. late_ack keeps
  // mem_ack high once mem_req has dropped.
  task automatic do_op(input logic rdn, wrn, sz, input logic [63:0] a, sd, input logic [4:0] r,
                       input int ack_lat, input logic [63:0] rdata, input bit late_ack,
                       output obs_t o);
    o = '{default: 0};
    o.ready0 = ex_ready;
    ex_valid = 1; mem_read = rdn; mem_write = wrn; size = sz; addr = a; store_data = sd; rd = r;
    @(negedge clk);
    ex_valid = 0; mem_read = 1'($urandom); mem_write = 1'($urandom); size = 1'($urandom);
    addr = {$urandom, $urandom}; store_data = {$urandom, $urandom}; rd = 5'($urandom);
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (mem_req) begin
        o.req_cycles++;
        if (o.req_cycles == 1) begin
          o.maddr = mem_addr; o.mwdata = mem_wdata; o.mwstrb = mem_wstrb; o.mwe = mem_we;
        end else if (mem_addr !== o.maddr || mem_wdata !== o.mwdata ||
                     mem_wstrb !== o.mwstrb || mem_we !== o.mwe) begin
          o.unstable = 1;
        end
      end
      mem_ack = (mem_req && ack_lat > 0 && o.req_cycles == ack_lat) ||
                (late_ack && !mem_req && o.req_cycles > 0);
      mem_rdata = (mem_ack && mem_req) ? rdata : {$urandom, $urandom};
      if (wb_valid) begin
        o.wbv_cycles++; o.lat = cyc;
        o.we = wb_we; o.fault = wb_fault; o.wrd = wb_rd; o.wdata = wb_data;
      end else if (o.wbv_cycles > 0) begin
        o.ready_after = ex_ready;
        break;
      end
      @(negedge clk);
    end
    if (o.wbv_cycles == 0) o.timed_out = 1;
    mem_ack = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++; if (ex_ready !== 1'b0) begin n_err++; $display("FAIL reset_ex_ready got=%b want=0", ex_ready); end
    n_cmp++; if ({mem_req, mem_we, wb_valid, wb_we, wb_fault} !== 5'b0) begin n_err++;
      $display("FAIL reset_ctrl got=%b want=00000", {mem_req, mem_we, wb_valid, wb_we, wb_fault}); end
    n_cmp++; if ({wb_data, mem_addr, mem_wdata, mem_wstrb, wb_rd} !== '0) begin n_err++;
      $display("FAIL reset_data got=%h/%h/%h/%h/%h want=0", wb_data, mem_addr, mem_wdata, mem_wstrb, wb_rd); end
    n_cmp++; if (dbg_state !== olivia_pkg::ST_IDLE) begin n_err++; $display("FAIL reset_state got=%0d want=IDLE", dbg_state); end
    rst = 1;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL release_ex_ready got=%b want=1", ex_ready); end
    @(negedge clk);
  endtask

  task automatic test_nonmem();
    obs_t o;
    do_op(0, 0, 1, 64'h1234, 64'h0, 5'd5, 0, 64'h0, 0, o);
    n_cmp++; if (o.lat != 1 || o.wbv_cycles != 1) begin n_err++; $display("FAIL nonmem_timing lat=%0d pulses=%0d want 1/1", o.lat, o.wbv_cycles); end
    n_cmp++; if ({o.we, o.fault} !== 2'b10) begin n_err++; $display("FAIL nonmem_we_fault got=%b want=10", {o.we, o.fault}); end
    n_cmp++; if (o.wrd !== 5'd5) begin n_err++; $display("FAIL nonmem_rd got=%0d want=5", o.wrd); end
    n_cmp++; if (o.wdata !== 64'h1234) begin n_err++; $display("FAIL nonmem_data got=%h want=1234", o.wdata); end
    n_cmp++; if (o.req_cycles != 0) begin n_err++; $display("FAIL nonmem_noreq got=%0d want=0", o.req_cycles); end
    n_cmp++; if (o.ready_after !== 1'b1) begin n_err++; $display("FAIL nonmem_ready_after got=%b want=1", o.ready_after); end
    do_op(0, 0, 0, 64'h77, 64'h0, 5'd31, 0, 64'h0, 0, o);
    n_cmp++; if (o.we !== 1'b0) begin n_err++; $display("FAIL nonmem_xzr_we got=%b want=0", o.we); end
  endtask

  task automatic test_ldur();
    obs_t o;
    do_op(1, 0, 1, 64'h40, 64'h0, 5'd3, 3, 64'hDEADBEEFCAFEF00D, 0, o);
    n_cmp++; if (o.req_cycles != 3) begin n_err++; $display("FAIL ldur_req_cycles got=%0d want=3", o.req_cycles); end
    n_cmp++; if (o.maddr !== 64'h40 || o.mwe !== 1'b0 || o.unstable) begin n_err++;
      $display("FAIL ldur_req_fields addr=%h we=%b unstable=%b want 40/0/0", o.maddr, o.mwe, o.unstable); end
    n_cmp++; if (o.wdata !== 64'hDEADBEEFCAFEF00D) begin n_err++; $display("FAIL ldur_data got=%h want=deadbeefcafef00d", o.wdata); end
    n_cmp++; if ({o.we, o.fault} !== 2'b10 || o.wrd !== 5'd3) begin n_err++;
      $display("FAIL ldur_wb we/fault=%b rd=%0d want 10/3", {o.we, o.fault}, o.wrd); end
    n_cmp++; if (o.lat != 4) begin n_err++; $display("FAIL ldur_latency got=%0d want=4", o.lat); end
    do_op(1, 0, 1, 64'h1000, 64'h0, 5'd4, 1, 64'h55, 0, o);
    n_cmp++; if (o.lat != 2 || o.req_cycles != 1) begin n_err++; $display("FAIL ldur_min_latency lat=%0d req=%0d want 2/1", o.lat, o.req_cycles); end
  endtask

  task automatic test_sturb();
    obs_t o;
    logic [63:0] sd;
    sd = {$urandom, $urandom};
    sd[7:0] = 8'hAB;
    do_op(0, 1, 0, 64'h45, sd, 5'd6, 2, 64'h0, 0, o);
    n_cmp++; if (o.mwstrb !== 8'h20) begin n_err++; $display("FAIL sturb_wstrb got=%h want=20", o.mwstrb); end
    n_cmp++; if (o.mwdata !== 64'hABABABABABABABAB) begin n_err++; $display("FAIL sturb_wdata got=%h want=abababababababab", o.mwdata); end
    n_cmp++; if (o.maddr !== 64'h40 || o.mwe !== 1'b1) begin n_err++; $display("FAIL sturb_addr_we addr=%h we=%b want 40/1", o.maddr, o.mwe); end
    n_cmp++; if ({o.we, o.fault} !== 2'b00) begin n_err++; $display("FAIL sturb_wb we/fault=%b want=00", {o.we, o.fault}); end
  endtask

  task automatic test_ldurb();
    obs_t o;
    do_op(1, 0, 0, 64'h13, 64'h0, 5'd8, 2, 64'h0011223344556677, 0, o);
    n_cmp++; if (o.wdata !== 64'h44) begin n_err++; $display("FAIL ldurb_data got=%h want=44", o.wdata); end
    n_cmp++; if (o.maddr !== 64'h10) begin n_err++; $display("FAIL ldurb_addr got=%h want=10", o.maddr); end
  endtask

  task automatic test_faults();
    obs_t o;
    do_op(1, 0, 1, 64'h44, 64'h0, 5'd2, 1, 64'h0, 0, o);
    n_cmp++; if ({o.we, o.fault} !== 2'b01 || o.req_cycles != 0 || o.lat != 1) begin n_err++;
      $display("FAIL misalign we/fault=%b req=%0d lat=%0d want 01/0/1", {o.we, o.fault}, o.req_cycles, o.lat); end
    do_op(1, 1, 0, 64'h8, 64'h0, 5'd2, 1, 64'h0, 0, o);
    n_cmp++; if ({o.we, o.fault} !== 2'b01 || o.req_cycles != 0) begin n_err++;
      $display("FAIL rw_both we/fault=%b req=%0d want 01/0", {o.we, o.fault}, o.req_cycles); end
    do_op(1, 0, 1, 64'h100, 64'h0, 5'd9, 0, 64'h0, 1, o);
    n_cmp++; if (o.req_cycles != 64) begin n_err++; $display("FAIL timeout_req_cycles got=%0d want=64", o.req_cycles); end
    n_cmp++; if ({o.we, o.fault} !== 2'b01 || o.lat != 65) begin n_err++;
      $display("FAIL timeout_wb we/fault=%b lat=%0d want 01/65", {o.we, o.fault}, o.lat); end
    n_cmp++; if (o.wbv_cycles != 1 || o.ready_after !== 1'b1) begin n_err++;
      $display("FAIL timeout_late_ack pulses=%0d ready=%b want 1/1", o.wbv_cycles, o.ready_after); end
    do_op(1, 0, 1, 64'h108, 64'h0, 5'd9, 64, 64'h1122, 0, o);
    n_cmp++; if (o.fault !== 1'b0 || o.wdata !== 64'h1122 || o.req_cycles != 64) begin n_err++;
      $display("FAIL ack_on_last fault=%b data=%h req=%0d want 0/1122/64", o.fault, o.wdata, o.req_cycles); end
  endtask

  task automatic test_reset_mid_access();
    int seen;
    ex_valid = 1; mem_read = 1; mem_write = 0; size = 1; addr = 64'h80; rd = 5'd7;
    @(negedge clk);
    ex_valid = 0;
    @(negedge clk);
    n_cmp++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL midrst_pre_req got=%b want=1", mem_req); end
    #2 rst = 0;
    #1;
    n_cmp++; if (mem_req !== 1'b0 || ex_ready !== 1'b0 || wb_valid !== 1'b0) begin n_err++;
      $display("FAIL midrst_async req=%b ready=%b wbv=%b want 0/0/0", mem_req, ex_ready, wb_valid); end
    @(negedge clk);
    rst = 1;
    #1;
    n_cmp++; if (ex_ready !== 1'b1) begin n_err++; $display("FAIL midrst_release_ready got=%b want=1", ex_ready); end
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (wb_valid || mem_req) seen++;
    end
    n_cmp++; if (seen != 0) begin n_err++; $display("FAIL midrst_discard got=%0d want=0", seen); end
  endtask

  task automatic test_back_to_back();
    obs_t o; exp_t e;
    logic rdn, wrn, sz; logic [63:0] a, sd, rdata, want; logic [4:0] r; int lat;
    for (int i = 0; i < 40; i++) begin
      rdn = 1'($urandom_range(0, 1)); wrn = 1'($urandom_range(0, 1)); sz = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) begin rdn = 1; wrn = 1; end
      else if (rdn && wrn) wrn = 0;
      a = {$urandom, $urandom};
      if (sz && $urandom_range(0, 3) != 0) a[2:0] = 3'd0;
      r = (i % 8 == 0) ? 5'd31 : 5'($urandom_range(0, 30));
      sd = {$urandom, $urandom}; rdata = {$urandom, $urandom};
      lat = ($urandom_range(0, 15) == 0) ? 0 : $urandom_range(1, 5);
      e = model(rdn, wrn, sz, a, sd, r, lat, rdata);
      if (e.chk_data) exp_q.push_back(e.data);
      do_op(rdn, wrn, sz, a, sd, r, lat, rdata, 0, o);
      n_cmp++; if (o.timed_out || o.ready0 !== 1'b1) begin n_err++; $display("FAIL rnd%0d_handshake timed_out=%b ready0=%b", i, o.timed_out, o.ready0); end
      n_cmp++; if (o.lat != e.lat || o.req_cycles != e.req_cycles || o.wbv_cycles != 1) begin n_err++;
        $display("FAIL rnd%0d_timing lat=%0d req=%0d pulses=%0d want %0d/%0d/1", i, o.lat, o.req_cycles, o.wbv_cycles, e.lat, e.req_cycles); end
      n_cmp++; if ({o.we, o.fault} !== {e.we, e.fault} || o.wrd !== r) begin n_err++;
        $display("FAIL rnd%0d_wb we/fault=%b rd=%0d want %b/%0d", i, {o.we, o.fault}, o.wrd, {e.we, e.fault}, r); end
      if (e.req_cycles > 0) begin
        n_cmp++; if (o.maddr !== e.maddr || o.mwe !== e.mwe || o.unstable) begin n_err++;
          $display("FAIL rnd%0d_req addr=%h we=%b unstable=%b want %h/%b/0", i, o.maddr, o.mwe, o.unstable, e.maddr, e.mwe); end
      end
      if (e.chk_wr) begin
        n_cmp++; if (o.mwstrb !== e.mwstrb || o.mwdata !== e.mwdata) begin n_err++;
          $display("FAIL rnd%0d_store strb=%h data=%h want %h/%h", i, o.mwstrb, o.mwdata, e.mwstrb, e.mwdata); end
      end
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        n_cmp++; if (o.wdata !== want) begin n_err++; $display("FAIL rnd%0d_data got=%h want=%h", i, o.wdata, want); end
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_nonmem();
    test_ldur();
    test_sturb();
    test_ldurb();
    test_faults();
    test_reset_mid_access();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
